// File: rtl/pll_lock_ctrl_if.sv
// Control/status bundle between the PLL lock controller and its user.
// The controller owns the slave modport; the user (or a bench) owns the master modport.
interface pll_lock_ctrl_if;
    // No valid/ready handshake. start is a level enable and clr_lost is a
    // single-cycle pulse. instlock_in may change at any time and is
    // synchronized inside the controller. Every status output is registered.
    logic       start;
    logic       instlock_in;
    logic       clr_lost;
    logic       pll_enable;
    logic       pll_rst_b;
    logic       locked;
    logic       lock_lost;
    logic [7:0] relock_count;
    logic [1:0] state;

    modport master (
        output start, instlock_in, clr_lost,
        input  pll_enable, pll_rst_b, locked, lock_lost, relock_count, state
    );

    modport slave (
        input  start, instlock_in, clr_lost,
        output pll_enable, pll_rst_b, locked, lock_lost, relock_count, state
    );
endinterface

// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock sequencer with lock filtering, loss detection and a relock counter.
// Define PLL_LOCK_CTRL_TIMEOUT_EN to re-reset the PLL when WAIT_LOCK lasts too long.
module pll_lock_ctrl #(
    parameter int RST_CYCLES     = 16,
    parameter int LOCK_CYCLES    = 1024,
    parameter int UNLOCK_THRESH  = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic            clk_160MHz,
    input  logic            rst_b,
    pll_lock_ctrl_if.slave  bus
);

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int LW = $clog2(LOCK_CYCLES + 1);
    localparam int UW = $clog2(UNLOCK_THRESH + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLL_RST   = 2'd1,
        WAIT_LOCK = 2'd2,
        LOCKED    = 2'd3
    } state_t;

    state_t        stateQ;
    logic          syncQ;
    logic          instS;
    logic [RW-1:0] rstCnt;
    logic [LW-1:0] lockCnt;
    logic [UW-1:0] unlockCnt;
    logic          pllEnQ;
    logic          pllRstBQ;
    logic          lockedQ;
    logic          lockLostQ;
    logic [7:0]    relockQ;

    logic          lockHit;
    logic          unlockHit;
    logic          timeoutHit;
    logic [7:0]    relockBase;
    logic [7:0]    relockNext;

    always_ff @(posedge clk_160MHz or negedge rst_b) begin
        if (!rst_b) begin
            syncQ <= 1'b0;
            instS <= 1'b0;
        end else begin
            syncQ <= bus.instlock_in;
            instS <= syncQ;
        end
    end

    assign lockHit   = instS && (lockCnt == LW'(LOCK_CYCLES - 1));
    assign unlockHit = !instS && (unlockCnt == UW'(UNLOCK_THRESH - 1));

    // A clear arriving with a relock event counts from zero, so the event still lands.
    assign relockBase = bus.clr_lost ? 8'd0 : relockQ;
    assign relockNext = (relockBase == 8'hFF) ? 8'hFF : relockBase + 8'd1;

`ifdef PLL_LOCK_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] toCnt;

    // Runs only while waiting for lock; every other state holds it at zero.
    always_ff @(posedge clk_160MHz or negedge rst_b) begin
        if (!rst_b) begin
            toCnt <= '0;
        end else if (bus.start && (stateQ == WAIT_LOCK) && !timeoutHit && !lockHit) begin
            toCnt <= toCnt + TW'(1);
        end else begin
            toCnt <= '0;
        end
    end

    assign timeoutHit = (toCnt == TW'(TIMEOUT_CYCLES - 1));
`else
    localparam int unusedTimeoutCycles = TIMEOUT_CYCLES;
    assign timeoutHit = 1'b0;
`endif

    always_ff @(posedge clk_160MHz or negedge rst_b) begin
        if (!rst_b) begin
            stateQ    <= IDLE;
            rstCnt    <= '0;
            lockCnt   <= '0;
            unlockCnt <= '0;
            pllEnQ    <= 1'b0;
            pllRstBQ  <= 1'b0;
            lockedQ   <= 1'b0;
            lockLostQ <= 1'b0;
            relockQ   <= 8'd0;
        end else begin
            if (bus.clr_lost) begin
                lockLostQ <= 1'b0;
                relockQ   <= 8'd0;
            end
            if (!bus.start) begin
                stateQ    <= IDLE;
                rstCnt    <= '0;
                lockCnt   <= '0;
                unlockCnt <= '0;
                pllEnQ    <= 1'b0;
                pllRstBQ  <= 1'b0;
                lockedQ   <= 1'b0;
            end else begin
                case (stateQ)
                    IDLE: begin
                        stateQ    <= PLL_RST;
                        rstCnt    <= '0;
                        lockCnt   <= '0;
                        unlockCnt <= '0;
                        pllEnQ    <= 1'b1;
                        pllRstBQ  <= 1'b0;
                    end
                    PLL_RST: begin
                        if (rstCnt == RW'(RST_CYCLES - 1)) begin
                            stateQ   <= WAIT_LOCK;
                            rstCnt   <= '0;
                            lockCnt  <= '0;
                            pllRstBQ <= 1'b1;
                        end else begin
                            rstCnt <= rstCnt + RW'(1);
                        end
                    end
                    WAIT_LOCK: begin
                        if (lockHit) begin
                            stateQ    <= LOCKED;
                            lockedQ   <= 1'b1;
                            unlockCnt <= '0;
                        end else if (timeoutHit) begin
                            stateQ    <= PLL_RST;
                            rstCnt    <= '0;
                            lockCnt   <= '0;
                            unlockCnt <= '0;
                            pllRstBQ  <= 1'b0;
                            relockQ   <= relockNext;
                        end else begin
                            lockCnt <= instS ? lockCnt + LW'(1) : '0;
                        end
                    end
                    LOCKED: begin
                        if (unlockHit) begin
                            stateQ    <= PLL_RST;
                            rstCnt    <= '0;
                            lockCnt   <= '0;
                            unlockCnt <= '0;
                            pllRstBQ  <= 1'b0;
                            lockedQ   <= 1'b0;
                            lockLostQ <= 1'b1;
                            relockQ   <= relockNext;
                        end else begin
                            unlockCnt <= instS ? '0 : unlockCnt + UW'(1);
                        end
                    end
                    default: stateQ <= IDLE;
                endcase
            end
        end
    end

    assign bus.pll_enable   = pllEnQ;
    assign bus.pll_rst_b    = pllRstBQ;
    assign bus.locked       = lockedQ;
    assign bus.lock_lost    = lockLostQ;
    assign bus.relock_count = relockQ;
    assign bus.state        = stateQ;

endmodule
